key_event_fifo: RTL and testbench

KEY_EVENT_FIFO -- requirements
Module: key_event_fifo

---
 rtl/key_event_fifo.sv | 204 ++++++++++++++++++++
 tb/tb_key_event_fifo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/key_event_fifo.sv
// key_event_fifo: keypad debouncer feeding a small first-word fall-through FIFO.
// A key must be stable for DEBOUNCE_CYCLES consecutive sampling edges before its
// code is pushed; holding a key never repeats. Release also needs a stable window.
// Optional build macro: KEY_FIFO_OVERWRITE_EN -- when defined, a press arriving
// while the FIFO is full (with no pop) evicts the oldest entry; when undefined the
// new press is dropped. Either way the sticky overflow flag is set.
module key_event_fifo #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int DEPTH           = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key,
   input  logic       key_valid,
   input  logic       rd_en,
   output logic [3:0] rd_data,
   output logic       empty,
   output logic       full,
   output logic [4:0] count,
   output logic       key_evt,
   output logic       overflow
);

   localparam int              PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]      DEB_LIM   = 4'(DEBOUNCE_CYCLES);
   localparam logic [4:0]      DEPTH_CNT = 5'(DEPTH);
   localparam logic [PW-1:0]   PTR_ONE   = PW'(1);

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } deb_state_t;

   deb_state_t    state_r, state_s;
   logic [3:0]    stab_cnt_r, stab_cnt_s;
   logic [3:0]    cap_code_r, cap_code_s;
   logic          push_s;

   logic [3:0]    mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r, wr_ptr_s;
   logic [PW-1:0] rd_ptr_r, rd_ptr_s;
   logic [4:0]    count_r, count_s;
   logic          empty_r, full_r;
   logic          key_evt_r;
   logic          overflow_r, overflow_s;
   logic          write_s;
   logic          pop_s;
   logic          fifo_empty_s, fifo_full_s;

   // Debouncer next-state: stability counting on press and on release.
   always_comb begin
      state_s    = state_r;
      stab_cnt_s = stab_cnt_r;
      cap_code_s = cap_code_r;
      push_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (key_valid) begin
               state_s    = ST_PRESS_WAIT;
               cap_code_s = key;
               stab_cnt_s = 4'd1;
            end else begin
               state_s    = ST_IDLE;
            end
         end
         ST_PRESS_WAIT: begin
            if (key_valid && (key == cap_code_r)) begin
               if ((stab_cnt_r + 4'd1) >= DEB_LIM) begin
                  // Accepting edge: the code has been stable long enough.
                  state_s    = ST_HELD;
                  stab_cnt_s = 4'd0;
                  push_s     = 1'b1;
               end else begin
                  stab_cnt_s = stab_cnt_r + 4'd1;
               end
            end else begin
               state_s    = ST_IDLE;
               stab_cnt_s = 4'd0;
            end
         end
         ST_HELD: begin
            if (!key_valid) begin
               state_s    = ST_RELEASE_WAIT;
               stab_cnt_s = 4'd1;
            end else begin
               state_s    = ST_HELD;
            end
         end
         ST_RELEASE_WAIT: begin
            if (!key_valid) begin
               if ((stab_cnt_r + 4'd1) >= DEB_LIM) begin
                  state_s    = ST_IDLE;
                  stab_cnt_s = 4'd0;
               end else begin
                  stab_cnt_s = stab_cnt_r + 4'd1;
               end
            end else begin
               // Release glitch: key is still down, go back without a new push.
               state_s    = ST_HELD;
               stab_cnt_s = 4'd0;
            end
         end
         default: begin
            state_s    = ST_IDLE;
            stab_cnt_s = 4'd0;
         end
      endcase
   end

   // Debouncer state, stability counter and captured code.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         stab_cnt_r <= 4'd0;
         cap_code_r <= 4'h0;
      end else begin
         state_r    <= state_s;
         stab_cnt_r <= stab_cnt_s;
         cap_code_r <= cap_code_s;
      end
   end

   // FIFO bookkeeping: decide write, pointer moves, occupancy and overflow.
   always_comb begin
      fifo_empty_s = (count_r == 5'd0);
      fifo_full_s  = (count_r == DEPTH_CNT);
      pop_s        = rd_en && !fifo_empty_s;
      write_s      = 1'b0;
      wr_ptr_s     = wr_ptr_r;
      rd_ptr_s     = rd_ptr_r;
      count_s      = count_r;
      overflow_s   = overflow_r;
      if (push_s && pop_s) begin
         // Simultaneous push and pop: occupancy unchanged, also when full.
         write_s  = 1'b1;
         wr_ptr_s = wr_ptr_r + PTR_ONE;
         rd_ptr_s = rd_ptr_r + PTR_ONE;
      end else if (push_s && fifo_full_s) begin
         overflow_s = 1'b1;
`ifdef KEY_FIFO_OVERWRITE_EN
         write_s  = 1'b1;
         wr_ptr_s = wr_ptr_r + PTR_ONE;
         rd_ptr_s = rd_ptr_r + PTR_ONE;
`else
         write_s  = 1'b0;
`endif
      end else if (push_s) begin
         write_s  = 1'b1;
         wr_ptr_s = wr_ptr_r + PTR_ONE;
         count_s  = count_r + 5'd1;
      end else if (pop_s) begin
         rd_ptr_s = rd_ptr_r + PTR_ONE;
         count_s  = count_r - 5'd1;
      end else begin
         count_s  = count_r;
      end
   end

   // FIFO pointers, registered status flags and the accept pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= 5'd0;
         empty_r    <= 1'b1;
         full_r     <= 1'b0;
         key_evt_r  <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         wr_ptr_r   <= wr_ptr_s;
         rd_ptr_r   <= rd_ptr_s;
         count_r    <= count_s;
         empty_r    <= (count_s == 5'd0);
         full_r     <= (count_s == DEPTH_CNT);
         key_evt_r  <= push_s;
         overflow_r <= overflow_s;
      end
   end

   // Storage array; contents are never visible while empty so no reset needed.
   always_ff @(posedge clk) begin
      if (write_s) begin
         mem_r[wr_ptr_r] <= cap_code_r;
      end
   end

   // First-word fall-through read port, forced to zero when empty.
   always_comb begin
      if (empty_r) begin
         rd_data = 4'h0;
      end else begin
         rd_data = mem_r[rd_ptr_r];
      end
   end

   assign empty    = empty_r;
   assign full     = full_r;
   assign count    = count_r;
   assign key_evt  = key_evt_r;
   assign overflow = overflow_r;

endmodule

// File: tb/tb_key_event_fifo.sv
// Directed bench for key_event_fifo (DEBOUNCE_CYCLES=4, DEPTH=4).
// Honours KEY_FIFO_OVERWRITE_EN for the expected overflow pop order.
module tb_key_event_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key;
   logic       key_valid;
   logic       rd_en;
   logic [3:0] rd_data;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       key_evt;
   logic       overflow;

   int total   = 0;
   int bad     = 0;
   int evt_cnt = 0;
   int evt_base;

   key_event_fifo #(.DEBOUNCE_CYCLES(4), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .key       (key),
      .key_valid (key_valid),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .key_evt   (key_evt),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Count accept pulses, sampled away from the rising edge.
   always @(negedge clk) begin
      if (key_evt === 1'b1) evt_cnt <= evt_cnt + 1;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Full press (4 stable edges) followed by a full release window.
   task automatic press_release(input logic [3:0] code);
      key = code; key_valid = 1'b1;
      step(4);
      key_valid = 1'b0;
      step(5);
   endtask

   task automatic pop_expect(input string tag, input logic [3:0] exp);
      check(tag, 8'(rd_data), 8'(exp));
      rd_en = 1'b1;
      step(1);
      rd_en = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_ovf [4];
`ifdef KEY_FIFO_OVERWRITE_EN
      exp_ovf = '{4'h2, 4'h3, 4'h4, 4'h5};
`else
      exp_ovf = '{4'h1, 4'h2, 4'h3, 4'h4};
`endif
      rst = 1'b1; key = 4'h0; key_valid = 1'b0; rd_en = 1'b0;
      step(2);
      check("rst_empty",    8'(empty),    8'd1);
      check("rst_full",     8'(full),     8'd0);
      check("rst_rd_data",  8'(rd_data),  8'd0);
      check("rst_count",    8'(count),    8'd0);
      check("rst_key_evt",  8'(key_evt),  8'd0);
      check("rst_overflow", 8'(overflow), 8'd0);
      rst = 1'b0;

      // Basic press of 7: accepted on the 4th stable edge.
      key = 4'h7; key_valid = 1'b1;
      step(3);
      check("p7_pre_count", 8'(count),   8'd0);
      check("p7_pre_evt",   8'(key_evt), 8'd0);
      step(1);
      check("p7_evt",       8'(key_evt), 8'd1);
      check("p7_count",     8'(count),   8'd1);
      check("p7_rd_data",   8'(rd_data), 8'h7);
      check("p7_empty",     8'(empty),   8'd0);
      step(1);
      check("p7_evt_drop",  8'(key_evt), 8'd0);
      step(10);
      check("p7_no_repeat", 8'(count),   8'd1);
      key_valid = 1'b0;
      step(5);
      pop_expect("p7_pop", 4'h7);
      check("p7_after_empty", 8'(empty),   8'd1);
      check("p7_after_rd",    8'(rd_data), 8'd0);

      // Pop on empty is ignored.
      rd_en = 1'b1;
      step(2);
      rd_en = 1'b0;
      check("empty_pop_count", 8'(count), 8'd0);

      // Push with rd_en on the same edge while empty: push only.
      key = 4'h6; key_valid = 1'b1; rd_en = 1'b1;
      step(4);
      rd_en = 1'b0;
      check("pe_count",   8'(count),   8'd1);
      check("pe_rd_data", 8'(rd_data), 8'h6);
      key_valid = 1'b0;
      step(5);
      pop_expect("pe_pop", 4'h6);

      // Bouncing key 3: three edges valid then drop, five times.
      evt_base = evt_cnt;
      for (int r = 0; r < 5; r++) begin
         key = 4'h3; key_valid = 1'b1;
         step(3);
         key_valid = 1'b0;
         step(1);
      end
      step(1);
      check("bounce_count", 8'(count), 8'd0);
      check("bounce_evts",  8'(evt_cnt - evt_base), 8'd0);

      // Long hold of 5 with a 2-edge release glitch: one push only.
      evt_base = evt_cnt;
      key = 4'h5; key_valid = 1'b1;
      step(20);
      key_valid = 1'b0;
      step(2);
      key_valid = 1'b1;
      step(28);
      key_valid = 1'b0;
      step(5);
      check("hold_evts",    8'(evt_cnt - evt_base), 8'd1);
      check("hold_count",   8'(count),   8'd1);
      pop_expect("hold_pop", 4'h5);

      // Fill, then overflow with a 5th press.
      press_release(4'h1);
      press_release(4'h2);
      press_release(4'h3);
      press_release(4'h4);
      check("fill_full",   8'(full),     8'd1);
      check("fill_count",  8'(count),    8'd4);
      check("fill_ovf",    8'(overflow), 8'd0);
      press_release(4'h5);
      check("ovf_flag",    8'(overflow), 8'd1);
      check("ovf_count",   8'(count),    8'd4);
      check("ovf_full",    8'(full),     8'd1);
      for (int i = 0; i < 4; i++) pop_expect("ovf_pop", exp_ovf[i]);
      check("ovf_drained", 8'(empty), 8'd1);

      // Full FIFO, pop on the accepting edge of press A.
      press_release(4'h1);
      press_release(4'h2);
      press_release(4'h3);
      press_release(4'h4);
      key = 4'hA; key_valid = 1'b1;
      step(3);
      rd_en = 1'b1;
      step(1);
      rd_en = 1'b0;
      check("pp_count",   8'(count),   8'd4);
      check("pp_evt",     8'(key_evt), 8'd1);
      check("pp_rd_data", 8'(rd_data), 8'h2);
      key_valid = 1'b0;
      step(5);
      pop_expect("pp_pop0", 4'h2);
      pop_expect("pp_pop1", 4'h3);
      pop_expect("pp_pop2", 4'h4);
      pop_expect("pp_pop3", 4'hA);
      check("pp_empty", 8'(empty), 8'd1);

      // Asynchronous reset mid-press with two entries stored.
      press_release(4'h1);
      press_release(4'h2);
      check("r_pre_count", 8'(count),    8'd2);
      check("r_pre_ovf",   8'(overflow), 8'd1);
      key = 4'h9; key_valid = 1'b1;
      step(2);
      #2 rst = 1'b1;
      #1;
      check("r_count",    8'(count),    8'd0);
      check("r_empty",    8'(empty),    8'd1);
      check("r_full",     8'(full),     8'd0);
      check("r_rd_data",  8'(rd_data),  8'd0);
      check("r_key_evt",  8'(key_evt),  8'd0);
      check("r_overflow", 8'(overflow), 8'd0);
      step(2);
      rst = 1'b0;
      step(3);
      check("r_post3_count", 8'(count),   8'd0);
      check("r_post3_evt",   8'(key_evt), 8'd0);
      step(1);
      check("r_post4_evt",   8'(key_evt), 8'd1);
      check("r_post4_count", 8'(count),   8'd1);
      check("r_post4_data",  8'(rd_data), 8'h9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
